adder_share_arb: RTL
====================

// Module: adder_share_arb
// PURPOSE
//  Round-robin arbiter and sequencer for the single shared 8-bit adder in the pipeline.
//  N_REQ requesters (e.g. PC increment, branch target, load/store address calculation) compete for the adder.
//  Each cycle, at most one requester is granted. Its operands pass through the adder.
//  The sum goes into a one-deep output register with a valid/ready handshake, tagged with the requester ID.
//  Sits between the decode/execute stage requesters and the shared adder instance.
// PARAMETERS
//  N_REQ   3   number of requesters (2..8)
//  ID_W    2   width of the requester tag; must satisfy 2**ID_W >= N_REQ
// PORTS
//  clock      in   1           rising-edge clock; the only clock
//  reset      in   1           synchronous, active-high reset
//  req_valid  in   N_REQ       request bit per requester; held until its ack
//  req_in1    in   8*N_REQ     operand 1 per requester, slice [8i+7:8i]
//  req_in2    in   8*N_REQ     operand 2 per requester, slice [8i+7:8i]
//  req_ack    out  N_REQ       one-hot one-cycle pulse: request i accepted this cycle
//  res_valid  out  1           output register holds a result
//  res_ready  in   1           consumer takes the result when res_valid & res_ready
//  res_sum    out  8           registered sum, modulo 256
//  res_carry  out  1           registered carry-out of the add
//  res_id     out  ID_W        index of the requester that produced the result
// BEHAVIOUR
//  - Reset (clock edge with reset=1):
//    - req_ack=0, res_valid=0, res_sum=0, res_carry=0, res_id=0.
//    - Priority pointer is set to 0.
//    - Any result in flight is discarded. Reset has priority over all other events.
//  - can_accept = !res_valid | res_ready. It is combinational from the register state and res_ready.
//  - Grant is combinational. The granted requester is the first i with req_valid[i]=1, searching from the pointer upward with wrap-around.
//    - req_ack[i] = grant[i] & can_accept.
//    - req_ack is never asserted for a requester whose req_valid is 0.
//  - On a cycle with any ack, at the next edge:
//    - {res_carry,res_sum} <= req_in1[i] + req_in2[i], a 9-bit result.
//    - res_id <= i, res_valid <= 1.
//    - Pointer <= (i+1) mod N_REQ.
//  - On a cycle with no ack: if res_valid & res_ready, then res_valid <= 0. The sum, carry and ID registers keep their values.
//  - Pointer changes only on an ack. An idle cycle does not rotate priority.
//  - Latency: request to res_valid is one cycle. Throughput is one result per cycle while the consumer keeps res_ready=1.
//  - Simultaneous consume and accept: the old result leaves and the new result loads at the same edge. res_valid stays 1 with no bubble.
//  - Backpressure (res_valid=1, res_ready=0):
//    - No ack is issued.
//    - Outputs hold stable until consumed.
//    - Requesters keep their operands stable.
//  - Fairness: a requester that holds req_valid is acked within N_REQ accepted grants.
//  - A requester may drop req_valid before its ack. The arbiter does not remember the request.
//  - State machine, two states. State is the same as res_valid.
//    - EMPTY -> FULL on an ack.
//    - FULL -> FULL on consume+ack, or while stalled.
//    - FULL -> EMPTY on a consume with no ack.
// STRUCTURE
//  - Shared package holds:
//    - localparam DATA_W = 8
//    - typedef for the 9-bit {carry,sum} result
//    - ID_W derivation function (clog2)
//  - One sub-module, rr_pick, which is purely combinational:
//    - Inputs: req[N_REQ-1:0], ptr[ID_W-1:0].
//    - Outputs: one-hot grant and binary index.
//  - Top level holds the operand mux, the 9-bit add, the output register, the pointer and the ack logic.
// TESTING
//  1. Reset held 2 cycles with req_valid=3'b111 -> req_ack=0 and res_valid=0 throughout. After release, first ack goes to requester 0.
//  2. Single request: req0 with in1=8'h7F, in2=8'h01, res_ready=1 -> ack0 in that cycle; next cycle res_sum=8'h80, res_carry=0, res_id=0.
//  3. Wrap/carry: in1=8'hFF, in2=8'h02 -> res_sum=8'h01, res_carry=1.
//  4. Round-robin: all 3 requests held, res_ready=1 -> acks 0,1,2,0 on consecutive cycles; res_id follows 0,1,2,0 one cycle later.
//  5. Backpressure: result pending with res_ready=0 for 3 cycles -> no acks; res_sum, res_id and res_valid stable. Raise res_ready -> same edge consumes and loads the next result, res_valid stays 1.
//  6. Reset mid-operation: res_valid=1 and req_valid=3'b110, assert reset 1 cycle -> res_valid=0, pointer=0. Next ack goes to requester 1.

Source files
------------

// File: rtl/adder_share_arb_pkg.sv
// Shared types and constants for the shared-adder arbiter: data width,
// the 9-bit {carry,sum} result and the requester-tag width helper.
package adder_share_arb_pkg;

  localparam int DATA_W = 8;

  typedef struct packed {
    logic              carry;
    logic [DATA_W-1:0] sum;
  } result_t;

  // The output register is the whole state: EMPTY means res_valid=0.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/adder_share_arb_if.sv
// Request/result bundle between the requesters/consumer (master) and the
// shared-adder arbiter (slave).
interface adder_share_arb_if
  import adder_share_arb_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int ID_W  = 2
);

  logic [N_REQ-1:0]        req_valid;
  logic [DATA_W*N_REQ-1:0] req_in1;
  logic [DATA_W*N_REQ-1:0] req_in2;
  logic [N_REQ-1:0]        req_ack;
  logic                    res_valid;
  logic                    res_ready;
  logic [DATA_W-1:0]       res_sum;
  logic                    res_carry;
  logic [ID_W-1:0]         res_id;

  modport master (
    output req_valid, req_in1, req_in2, res_ready,
    input  req_ack, res_valid, res_sum, res_carry, res_id
  );

  modport slave (
    input  req_valid, req_in1, req_in2, res_ready,
    output req_ack, res_valid, res_sum, res_carry, res_id
  );

endinterface

// File: rtl/adder_share_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i,
// wrapping around, returned as a one-hot grant and a binary index.
module rr_pick #(
  parameter int N_REQ = 3,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [ID_W-1:0]  idx_o
);

  logic found;
  int   cand;

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and a latch is never inferred.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = 0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = (int'(ptr_i) + k) % N_REQ;
      if (!found && req_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = ID_W'(cand);
      end
    end
  end

endmodule

// File: rtl/adder_share_arb.sv
// Round-robin arbiter for the single shared 8-bit adder: grants one requester
// per cycle and registers its tagged {carry,sum} behind a valid/ready handshake.
module adder_share_arb
  import adder_share_arb_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int ID_W  = id_width(N_REQ)
) (
  input  logic                clock,
  input  logic                reset,
  adder_share_arb_if.slave    bus
);

  logic [N_REQ-1:0]  grant;
  logic [ID_W-1:0]   idx;
  logic              can_accept;
  logic              any_ack;
  logic [DATA_W-1:0] op1;
  logic [DATA_W-1:0] op2;
  result_t           sum_new;

  state_e            state_d, state_q;
  logic [ID_W-1:0]   ptr_d,   ptr_q;
  logic [ID_W-1:0]   id_d,    id_q;
  result_t           res_d,   res_q;

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .req_i   (bus.req_valid),
    .ptr_i   (ptr_q),
    .grant_o (grant),
    .idx_o   (idx)
  );

  // A slot is free when empty or when the held result leaves this same edge.
  assign can_accept  = (state_q == EMPTY) || bus.res_ready;
  assign bus.req_ack = (can_accept && !reset) ? grant : '0;
  assign any_ack     = |bus.req_ack;

  assign op1     = bus.req_in1[int'(idx)*DATA_W +: DATA_W];
  assign op2     = bus.req_in2[int'(idx)*DATA_W +: DATA_W];
  assign sum_new = {1'b0, op1} + {1'b0, op2};

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    res_d   = res_q;
    if (any_ack) begin
      state_d = FULL;
      ptr_d   = (idx == ID_W'(N_REQ - 1)) ? '0 : idx + ID_W'(1);
      id_d    = idx;
      res_d   = sum_new;
    end else if (state_q == FULL && bus.res_ready) begin
      state_d = EMPTY;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
      id_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      res_q   <= res_d;
    end
  end

  assign bus.res_valid = (state_q == FULL);
  assign bus.res_sum   = res_q.sum;
  assign bus.res_carry = res_q.carry;
  assign bus.res_id    = id_q;

endmodule
